data_sram_responder: RTL and testbench

In-order SRAM-like slave that answers the data-side request interface driven by the EXE stage: it accepts `req/wr/size/wstrb/addr/wdata` with `addr_ok`, then returns `data_ok/rdata` after a fixed latency. It is backed by an internal word-addressed memory and serves as the data-memory model and latency/back-pressure generator in the CPU test environment. Responses come back in order, and a bounded outstanding-request queue throttles `addr_ok`.

---
 rtl/data_sram_responder.sv | 108 ++++++++++
 tb/tb_data_sram_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// In-order SRAM-like data-side slave: fixed LATENCY, DEPTH-bounded outstanding queue.
// Define DATA_SRAM_RESP_STALL_EN to add LFSR-driven random addr_ok stalls.
`timescale 1ns/1ps
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TW-1:0] TINIT = TW'(LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  logic [31:0]      mem [2**ADDR_W];
  logic [31:0]      data_q [DEPTH];
  logic [TW-1:0]    tmr_q [DEPTH];
  logic [DEPTH-1:0] isrd_q;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      last_q;
  logic [ADDR_W-1:0] idx;
  logic [31:0]      rword;
  logic             stall, push, pop;
  logic             unused_bits;

  assign idx   = data_sram_addr[ADDR_W+1:2];
  assign rword = mem[idx];
  assign unused_bits = ^{data_sram_size,
                         data_sram_addr[31:ADDR_W+2],
                         data_sram_addr[1:0]};

`ifdef DATA_SRAM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                   lfsr_q[15:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign data_sram_addr_ok = ~reset & (cnt_q < DEPTH_C) & ~stall;
  assign push = data_sram_req & data_sram_addr_ok;
  // An entry stays counted through its data_ok cycle, so a freed slot shows next cycle
  assign pop  = (cnt_q != '0) & (tmr_q[rptr_q] == '0);

  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = pop ? (isrd_q[rptr_q] ? data_q[rptr_q] : 32'h0)
                                 : last_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push & ~pop)      cnt_d = cnt_q + 1'b1;
    else if (pop & ~push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
      isrd_q <= '0;
      for (int i = 0; i < DEPTH; i++) tmr_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (tmr_q[i] != '0) tmr_q[i] <= tmr_q[i] - 1'b1;
      if (push) begin
        tmr_q[wptr_q]  <= TINIT;
        isrd_q[wptr_q] <= ~data_sram_wr;
        wptr_q <= (wptr_q == PLAST) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= (rptr_q == PLAST) ? '0 : rptr_q + 1'b1;
        last_q <= data_sram_rdata;
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push & data_sram_wr)
      for (int i = 0; i < 4; i++)
        if (data_sram_wstrb[i])
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    if (push) data_q[wptr_q] <= rword;
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder with a cycle-level response model.
// Directed cases cover write/read, strobes, full queue, streaming and reset.
`timescale 1ns/1ps
module tb_data_sram_responder;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_nx;
  logic        req, wr, req2;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        aok, dok, aok2, dok2;
  logic [31:0] rdata, rdata2;

  data_sram_responder #(.ADDR_W(10), .LATENCY(LAT), .DEPTH(DEP)) u_dut (
    .clk(clk), .reset(rst),
    .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok), .data_sram_data_ok(dok), .data_sram_rdata(rdata)
  );

  data_sram_responder #(.ADDR_W(4), .LATENCY(4), .DEPTH(2)) u_full (
    .clk(clk), .reset(rst),
    .data_sram_req(req2), .data_sram_wr(1'b1), .data_sram_size(2'd2),
    .data_sram_wstrb(4'h0), .data_sram_addr(32'h0), .data_sram_wdata(32'h0),
    .data_sram_addr_ok(aok2), .data_sram_data_ok(dok2), .data_sram_rdata(rdata2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mm [1024];
  logic [31:0] mlast = 32'h0;
  logic [15:0] mlfsr = 16'hACE1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: each accepted request owns a queue slot until its response cycle
  always @(negedge clk) begin
    logic        stall, eok, edok, fb;
    logic [31:0] erd;
    logic [9:0]  ix;
    rsp_t        e;
    if (chk_en) begin
`ifdef DATA_SRAM_RESP_STALL_EN
      stall = mlfsr[0];
`else
      stall = 1'b0;
`endif
      eok  = !rst && (q.size() < DEP) && !stall;
      edok = !rst && (q.size() > 0) && (q[0].due == cyc);
      erd  = rst ? 32'h0 : (edok ? q[0].data : mlast);
      chk("addr_ok", {31'h0, aok}, {31'h0, eok});
      chk("data_ok", {31'h0, dok}, {31'h0, edok});
      chk("rdata", rdata, erd);
      if (rst) begin
        q.delete();
        mlast = 32'h0;
        mlfsr = 16'hACE1;
      end else begin
        if (edok) begin
          mlast = q[0].data;
          void'(q.pop_front());
        end
        if (req && eok) begin
          ix = addr[11:2];
          e.due  = cyc + LAT;
          e.data = wr ? 32'h0 : mm[ix];
          q.push_back(e);
          if (wr)
            for (int i = 0; i < 4; i++)
              if (wstrb[i]) mm[ix][8*i +: 8] = wdata[8*i +: 8];
        end
        fb = mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5];
        mlfsr = (mlfsr >> 1) | {fb, 15'h0};
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic r2 = 1'b0);
    @(posedge clk);
    #1;
    rst   = rst_nx;
    req   = r;
    wr    = w;
    wstrb = s;
    addr  = a;
    wdata = d;
    req2  = r2;
    size  = 2'($urandom_range(0, 2));
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic put(input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    step(1'b1, w, s, a, d);
    while (!aok && n < 50) begin
      step(1'b1, w, s, a, d);
      n++;
    end
    chk("accept", {31'h0, aok}, 32'h1);
  endtask

  function automatic logic [31:0] sv(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  logic ao2 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic do2 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; rst_nx = 1'b1;
    req = 1'b0; wr = 1'b0; req2 = 1'b0; size = 2'd0;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    idle();
    chk("rst_addr_ok", {31'h0, aok}, 32'h0);
    chk("rst_data_ok", {31'h0, dok}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr_ok2", {31'h0, aok2}, 32'h0);
    rst_nx = 1'b0;
`ifdef DATA_SRAM_RESP_STALL_EN
    idle();
    chk("stall_first", {31'h0, aok}, 32'h0);
    idle();
    chk("stall_second", {31'h0, aok}, 32'h1);
    for (int i = 0; i < 16; i++) put(1'b1, 4'hF, 32'(i * 4), sv(i));
    for (int k = 0; k < 150; k++)
      step(1'b1, 1'b0, 4'h0, {20'($urandom), 6'h0, 4'($urandom), 2'b00}, 32'h0);
`else
    idle();
    chk("addr_ok_up", {31'h0, aok}, 32'h1);
    step(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    chk("wr_accept", {31'h0, aok}, 32'h1);
    step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    chk("wr_lat_early", {31'h0, dok}, 32'h0);
    idle();
    chk("wr_rsp_ok", {31'h0, dok}, 32'h1);
    chk("wr_rsp_data", rdata, 32'h0);
    idle();
    chk("rd_rsp_ok", {31'h0, dok}, 32'h1);
    chk("rd_rsp_data", rdata, 32'hDEADBEEF);
    idle();
    chk("rsp_gap", {31'h0, dok}, 32'h0);
    chk("rdata_hold", rdata, 32'hDEADBEEF);

    step(1'b1, 1'b1, 4'hF, 32'h200, 32'h11223344);
    step(1'b1, 1'b1, 4'b0100, 32'h200, 32'hAAAAAAAA);
    step(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    idle();
    idle();
    chk("strb_ok", {31'h0, dok}, 32'h1);
    chk("strb_data", rdata, 32'h11AA3344);

    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      chk($sformatf("full_aok_%0d", k), {31'h0, aok2}, {31'h0, ao2[k]});
      chk($sformatf("full_dok_%0d", k), {31'h0, dok2}, {31'h0, do2[k]});
    end
    repeat (6) idle();

    for (int i = 0; i < 8; i++) put(1'b1, 4'hF, 32'(i * 4), sv(i));
    repeat (4) idle();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) step(1'b1, 1'b0, 4'h0, 32'(k * 4), 32'h0);
      else       idle();
      if (k < 8) chk("stream_aok", {31'h0, aok}, 32'h1);
      if (k >= 2) begin
        chk("stream_dok", {31'h0, dok}, 32'h1);
        chk("stream_data", rdata, sv(k - 2));
      end else begin
        chk("stream_quiet", {31'h0, dok}, 32'h0);
      end
    end

    step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
    rst_nx = 1'b1;
    for (int k = 0; k < 2; k++) begin
      idle();
      chk("midrst_dok", {31'h0, dok}, 32'h0);
      chk("midrst_aok", {31'h0, aok}, 32'h0);
    end
    rst_nx = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle();
      chk("postrst_dok", {31'h0, dok}, 32'h0);
      chk("postrst_aok", {31'h0, aok}, 32'h1);
    end
    step(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    idle();
    idle();
    chk("mem_kept_ok", {31'h0, dok}, 32'h1);
    chk("mem_kept", rdata, 32'hDEADBEEF);

    for (int i = 0; i < 16; i++) put(1'b1, 4'hF, 32'(i * 4), sv(i) ^ 32'h5A5A_0000);
`endif
    for (int k = 0; k < 400; k++) begin
      rst_nx = (k == 200 || k == 201);
      step(1'($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom),
           {20'($urandom), 6'h0, 4'($urandom), 2'($urandom)}, $urandom);
    end
    rst_nx = 1'b0;
    repeat (8) idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
